// File: rtl/dma_stream_pkg.sv
// Shared definitions for the C2H stream frame receive path: default widths,
// beat-count helper and the receive state encoding.
package dma_stream_pkg;

    localparam int FRAME_W_DEF = 16000;
    localparam int BEAT_W_DEF  = 512;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DROP    = 2'd2
    } rx_state_e;

    function automatic int calc_beats(input int frame_w, input int beat_w);
        return (frame_w + beat_w - 1) / beat_w;
    endfunction

endpackage

// File: rtl/dma_seq_checker.sv
// Frame sequence checker: compares each delivered frame's sequence word with
// the expected value and resynchronises on the observed value after every frame.
module dma_seq_checker
    import dma_stream_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic [CNT_W-1:0] value,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [CNT_W-1:0] exp_seq_r;
    logic             err_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             mismatch_s;

    assign mismatch_s = strobe && (value != exp_seq_r);

    // Expected-sequence tracking, error pulse and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_seq_r <= CNT_W'(1);
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            err_r <= mismatch_s;
            if (mismatch_s) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
            if (strobe) begin
                exp_seq_r <= value + CNT_W'(1);
            end
        end
    end

    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: rtl/dma_stream_frame_rx.sv
// C2H stream receiver: reassembles BEAT_W-bit AXI-Stream beats into one FRAME_W-bit
// frame presented with an enable/next handshake. Optional SEQ_CHECK_EN adds a sequence checker.
module dma_stream_frame_rx
    import dma_stream_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int BEAT_W  = BEAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               m_axis_c2h_aclk,
    input  logic               rstn_en,
    input  logic [BEAT_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic [FRAME_W-1:0] io_data,
    output logic               io_enable,
    input  logic               data_next,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               len_err,
`ifdef SEQ_CHECK_EN
    output logic               seq_err,
    output logic [CNT_W-1:0]   seq_err_cnt,
`endif
    output logic [CNT_W-1:0]   len_err_cnt
);

    localparam int BEATS  = calc_beats(FRAME_W, BEAT_W);
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_W = FRAME_W - (BEATS - 1) * BEAT_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);

    rx_state_e          state_r, state_nxt_s;
    logic [IDX_W-1:0]   beat_idx_r, beat_idx_nxt_s;
    logic               tready_r, io_enable_r, len_err_r, len_err_nxt_s;
    logic [CNT_W-1:0]   frame_cnt_r, len_err_cnt_r;
    logic               accept_s, wr_s, deliver_s;
    logic [FRAME_W-1:0] frame_s;

    assign accept_s  = s_axis_tvalid && tready_r;
    assign wr_s      = accept_s && (state_r == COLLECT);
    assign deliver_s = (state_r == HOLD) && data_next;

    // Next-state and beat-index logic, including framing-error detection
    always_comb begin
        state_nxt_s    = state_r;
        beat_idx_nxt_s = beat_idx_r;
        len_err_nxt_s  = 1'b0;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (beat_idx_r == IDX_LAST) begin
                        if (s_axis_tlast) begin
                            state_nxt_s = HOLD;
                        end else begin
                            len_err_nxt_s  = 1'b1;
                            state_nxt_s    = DROP;
                            beat_idx_nxt_s = '0;
                        end
                    end else if (s_axis_tlast) begin
                        len_err_nxt_s  = 1'b1;
                        beat_idx_nxt_s = '0;
                    end else begin
                        beat_idx_nxt_s = beat_idx_r + IDX_W'(1);
                    end
                end else begin
                    beat_idx_nxt_s = beat_idx_r;
                end
            end
            HOLD: begin
                if (data_next) begin
                    state_nxt_s    = COLLECT;
                    beat_idx_nxt_s = '0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DROP: begin
                if (accept_s && s_axis_tlast) begin
                    state_nxt_s    = COLLECT;
                    beat_idx_nxt_s = '0;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s    = COLLECT;
                beat_idx_nxt_s = '0;
            end
        endcase
    end

    // State, handshake outputs and counters; tready stays low the first cycle after reset
    always_ff @(posedge m_axis_c2h_aclk or negedge rstn_en) begin
        if (!rstn_en) begin
            state_r       <= COLLECT;
            beat_idx_r    <= '0;
            tready_r      <= 1'b0;
            io_enable_r   <= 1'b0;
            len_err_r     <= 1'b0;
            frame_cnt_r   <= '0;
            len_err_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            beat_idx_r  <= beat_idx_nxt_s;
            tready_r    <= (state_nxt_s != HOLD);
            io_enable_r <= (state_nxt_s == HOLD);
            len_err_r   <= len_err_nxt_s;
            if (len_err_nxt_s) begin
                len_err_cnt_r <= len_err_cnt_r + CNT_W'(1);
            end
            if (deliver_s) begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < BEATS; k++) begin : g_slice
        localparam int SW = (k == BEATS - 1) ? LAST_W : BEAT_W;
        logic [SW-1:0] slice_r;

        // Capture beat k; slices keep stale data until the next frame overwrites them
        always_ff @(posedge m_axis_c2h_aclk or negedge rstn_en) begin
            if (!rstn_en) begin
                slice_r <= '0;
            end else if (wr_s && (beat_idx_r == IDX_W'(k))) begin
                slice_r <= s_axis_tdata[SW-1:0];
            end
        end

        assign frame_s[k*BEAT_W +: SW] = slice_r;
    end

`ifdef SEQ_CHECK_EN
    dma_seq_checker #(
        .CNT_W (CNT_W)
    ) u_seq_checker (
        .clk     (m_axis_c2h_aclk),
        .rst_n   (rstn_en),
        .strobe  (deliver_s),
        .value   (frame_s[CNT_W-1:0]),
        .err     (seq_err),
        .err_cnt (seq_err_cnt)
    );
`endif

    assign s_axis_tready = tready_r;
    assign io_data       = frame_s;
    assign io_enable     = io_enable_r;
    assign frame_cnt     = frame_cnt_r;
    assign len_err       = len_err_r;
    assign len_err_cnt   = len_err_cnt_r;

endmodule

// File: tb/tb_dma_stream_frame_rx.sv
// Self-checking bench for dma_stream_frame_rx: table-driven frame vectors, a frame
// scoreboard, and hand-written backpressure, reset and sequence-check sequences.
module tb_dma_stream_frame_rx;

    localparam int FRAME_W = 16000;
    localparam int BEAT_W  = 512;
    localparam int CNT_W   = 32;
    localparam int BEATS   = 32;
    localparam int LAST_W  = FRAME_W - (BEATS - 1) * BEAT_W;

    logic               clk = 1'b0;
    logic               rstn_en = 1'b0;
    logic [BEAT_W-1:0]  s_axis_tdata = '0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tlast = 1'b0;
    logic               s_axis_tready;
    logic [FRAME_W-1:0] io_data;
    logic               io_enable;
    logic               data_next = 1'b1;
    logic [CNT_W-1:0]   frame_cnt;
    logic               len_err;
    logic [CNT_W-1:0]   len_err_cnt;
`ifdef SEQ_CHECK_EN
    logic               seq_err;
    logic [CNT_W-1:0]   seq_err_cnt;
`endif

    dma_stream_frame_rx dut (
        .m_axis_c2h_aclk (clk),
        .rstn_en         (rstn_en),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .io_data         (io_data),
        .io_enable       (io_enable),
        .data_next       (data_next),
        .frame_cnt       (frame_cnt),
        .len_err         (len_err),
`ifdef SEQ_CHECK_EN
        .seq_err         (seq_err),
        .seq_err_cnt     (seq_err_cnt),
`endif
        .len_err_cnt     (len_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int seed;
        int nbeats;
        bit deliver;
        int err_beat;
    } vec_t;

    vec_t               vecs[8];
    logic [FRAME_W-1:0] sb_q[$];
    int                 n_checks = 0;
    int                 n_fail = 0;
    int                 exp_frames = 0;
    int                 exp_len_errs = 0;
    bit                 hold_seen = 1'b0;

    function automatic logic [BEAT_W-1:0] beat_of(input int seed, input int k);
        logic [BEAT_W-1:0] b;
        b = '0;
        for (int j = 0; j < BEAT_W / 32; j++) begin
            b[j*32 +: 32] = 32'(seed + k) + (32'(j) << 24);
        end
        return b;
    endfunction

    function automatic logic [FRAME_W-1:0] frame_of(input int seed);
        logic [FRAME_W-1:0] f;
        logic [BEAT_W-1:0]  tmp;
        f = '0;
        for (int k = 0; k < BEATS - 1; k++) begin
            f[k*BEAT_W +: BEAT_W] = beat_of(seed, k);
        end
        tmp = beat_of(seed, BEATS - 1);
        f[(BEATS-1)*BEAT_W +: LAST_W] = tmp[LAST_W-1:0];
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FRAME_W-1:0] exp);
        int bad;
        n_checks++;
        if (io_data !== exp) begin
            n_fail++;
            bad = 0;
            for (int k = BEATS - 1; k >= 0; k--) begin
                if (io_data[k*BEAT_W +: 64] !== exp[k*BEAT_W +: 64]) bad = k;
            end
            $display("FAIL %s: beat %0d low word got %0h expected %0h", name, bad,
                     io_data[bad*BEAT_W +: 64], exp[bad*BEAT_W +: 64]);
        end
    endtask

    // Scoreboard: each newly presented frame must match the oldest expected frame
    always @(negedge clk) begin
        if (io_enable === 1'b1) begin
            if (!hold_seen) begin
                hold_seen = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got a frame, expected none (t=%0t)", $time);
                end else begin
                    chk_frame("frame_data", sb_q.pop_front());
                end
            end
        end else begin
            hold_seen = 1'b0;
        end
    end

    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic last);
        int budget;
        budget = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        while (s_axis_tready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            chk("tready_timeout", 64'(s_axis_tready), 64'(1));
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int seed, input int nbeats, input int err_beat);
        for (int k = 0; k < nbeats; k++) begin
            send_beat(beat_of(seed, k), (k == nbeats - 1));
            chk("len_err_pulse", 64'(len_err), 64'(k == err_beat));
        end
        if (err_beat >= 0) exp_len_errs++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn_en       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sb_q.delete();
        exp_frames   = 0;
        exp_len_errs = 0;
        #1;
        chk("rst_io_enable", 64'(io_enable), 64'(0));
        chk("rst_io_data_zero", 64'(io_data === '0), 64'(1));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("rst_len_err", 64'(len_err), 64'(0));
        chk("rst_len_err_cnt", 64'(len_err_cnt), 64'(0));
        chk("rst_tready", 64'(s_axis_tready), 64'(0));
        @(negedge clk);
        rstn_en = 1'b1;
        #1;
        chk("tready_after_release", 64'(s_axis_tready), 64'(0));
        @(negedge clk);
        chk("tready_second_cycle", 64'(s_axis_tready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FRAME_W-1:0] held;

        vecs[0] = '{0,   32, 1'b1, -1};
        vecs[1] = '{100, 6,  1'b0, 5};
        vecs[2] = '{200, 32, 1'b1, -1};
        vecs[3] = '{300, 40, 1'b0, 31};
        vecs[4] = '{400, 32, 1'b1, -1};
        vecs[5] = '{500, 1,  1'b0, 0};
        vecs[6] = '{600, 33, 1'b0, 31};
        vecs[7] = '{700, 32, 1'b1, -1};

        data_next = 1'b1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].deliver) sb_q.push_back(frame_of(vecs[i].seed));
            send_frame(vecs[i].seed, vecs[i].nbeats, vecs[i].err_beat);
            chk("io_enable_latency", 64'(io_enable), 64'(vecs[i].deliver));
            if (vecs[i].deliver) exp_frames++;
            @(negedge clk);
            @(negedge clk);
            chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
            chk("len_err_cnt", 64'(len_err_cnt), 64'(exp_len_errs));
            chk("io_enable_idle", 64'(io_enable), 64'(0));
        end

        // Backpressure: consumer stalls for 10 cycles
        data_next = 1'b0;
        held = frame_of(900);
        sb_q.push_back(held);
        send_frame(900, 32, -1);
        for (int c = 0; c < 10; c++) begin
            chk("bp_tready", 64'(s_axis_tready), 64'(0));
            chk("bp_io_enable", 64'(io_enable), 64'(1));
            chk("bp_data_stable", 64'(io_data === held), 64'(1));
            chk("bp_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
            @(negedge clk);
        end
        data_next = 1'b1;
        @(negedge clk);
        exp_frames++;
        chk("bp_release_cnt", 64'(frame_cnt), 64'(exp_frames));
        chk("bp_release_tready", 64'(s_axis_tready), 64'(1));
        chk("bp_release_enable", 64'(io_enable), 64'(0));

        // Reset in the middle of a frame
        for (int k = 0; k < 11; k++) begin
            send_beat(beat_of(1000, k), 1'b0);
        end
        do_reset();
        sb_q.push_back(frame_of(1100));
        send_frame(1100, 32, -1);
        chk("post_reset_enable", 64'(io_enable), 64'(1));
        exp_frames++;
        @(negedge clk);
        @(negedge clk);
        chk("post_reset_frame_cnt", 64'(frame_cnt), 64'(1));
        chk("post_reset_len_err_cnt", 64'(len_err_cnt), 64'(0));

`ifdef SEQ_CHECK_EN
        begin
            int seqs[5];
            int serr[5];
            int serr_total;
            seqs = '{1, 2, 3, 5, 6};
            serr = '{0, 0, 0, 1, 0};
            serr_total = 0;
            do_reset();
            chk("rst_seq_err_cnt", 64'(seq_err_cnt), 64'(0));
            for (int i = 0; i < 5; i++) begin
                sb_q.push_back(frame_of(seqs[i]));
                send_frame(seqs[i], 32, -1);
                @(negedge clk);
                serr_total += serr[i];
                chk("seq_err_pulse", 64'(seq_err), 64'(serr[i]));
                chk("seq_err_cnt", 64'(seq_err_cnt), 64'(serr_total));
                @(negedge clk);
                chk("seq_err_clear", 64'(seq_err), 64'(0));
            end
        end
`endif

        @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_stream_frame_rx.md
Name: dma_stream_frame_rx

Overview:
- Receive end of the C2H DMA stream: accepts BEAT_W-bit AXI-Stream beats and reassembles them into one FRAME_W-bit frame.
- Presents each reassembled frame with an enable/next style handshake, mirroring the frame-level interface on the transmit side.
- Used in loopback simulation and on the card to rebuild and check wide io_data frames after packing.

Parameters:
- FRAME_W, 16000, frame width in bits.
- BEAT_W, 512, stream beat width in bits.
- BEATS, ceil(FRAME_W/BEAT_W) = 32, derived localparam: beats per frame.
- CNT_W, 32, width of frame/error counters.

Ports:
- m_axis_c2h_aclk  in  1  sole clock.
- rstn_en  in  1  asynchronous active-low reset.
- s_axis_tdata  in  BEAT_W  beat payload; beat 0 carries frame bits [BEAT_W-1:0].
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tready  out  1  beat accept.
- io_data  out  FRAME_W  reassembled frame.
- io_enable  out  1  frame valid.
- data_next  in  1  consumer takes the frame.
- frame_cnt  out  CNT_W  count of frames delivered.
- len_err  out  1  one-cycle pulse on a framing error.
- len_err_cnt  out  CNT_W  framing error count.

Behaviour:
- Reset (async assert, sync release): state=COLLECT, beat_idx=0, s_axis_tready=0 for the first cycle after release and then 1. io_enable=0, io_data=0, frame_cnt=0, len_err=0, len_err_cnt=0.
- A beat is accepted when tvalid && tready. Beat k is written to io_data[k*BEAT_W +: BEAT_W]. Bits at or above FRAME_W are discarded; the last beat uses only its low FRAME_W-(BEATS-1)*BEAT_W = 128 bits.
- States:
  - COLLECT: tready=1. On accept:
    - beat_idx==BEATS-1 and tlast=1: go to HOLD.
    - beat_idx<BEATS-1 and tlast=1 (short frame): pulse len_err, len_err_cnt+1, beat_idx=0, stay in COLLECT. The partial frame is never presented.
    - beat_idx==BEATS-1 and tlast=0 (long frame): pulse len_err, len_err_cnt+1, go to DROP.
    - otherwise: beat_idx+1.
  - HOLD: io_enable=1, tready=0, io_data stable. When data_next=1: io_enable=0 next cycle, frame_cnt+1, beat_idx=0, go to COLLECT.
  - DROP: tready=1, accepted beats are discarded. An accepted tlast returns to COLLECT with beat_idx=0. No further error pulse is generated in DROP.
- Latency: io_enable rises the cycle after the final beat is accepted. Throughput is one beat per cycle in COLLECT. Minimum frame period is BEATS+1 cycles with data_next held at 1.
- data_next while io_enable=0 is ignored.
- Counters wrap modulo 2^CNT_W.
- io_data is not cleared between frames; stale upper bits stay until overwritten.
- Reset mid-frame or mid-HOLD discards all state immediately.

Optional Feature:
- Macro: SEQ_CHECK_EN.
- When defined:
  - Adds output seq_err (1-bit pulse) and seq_err_cnt (CNT_W).
  - Internal expected counter exp_seq resets to 1.
  - On each data_next handshake in HOLD, io_data[CNT_W-1:0] is compared to exp_seq. A mismatch pulses seq_err and increments seq_err_cnt. exp_seq is then set to io_data[CNT_W-1:0]+1 (resynchronises).
- When undefined: these ports and all related logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dma_stream_pkg:
  - FRAME_W/BEAT_W defaults.
  - BEATS computation function.
  - State enum constants COLLECT/HOLD/DROP.
- One natural sub-module: dma_seq_checker, instantiated only under SEQ_CHECK_EN. Inputs: clock, reset, strobe, value. Outputs: err pulse, err count.
- The beat-slice write stays inline.

Test Plan:
- Nominal: 32 beats, beat k = {16{32'(k)}}, tlast on beat 31, data_next held 1 → io_enable high 1 cycle after beat 31. io_data[511:0] = beat 0, io_data[15999:15872] = low 128 bits of beat 31. frame_cnt=1.
- Backpressure: data_next=0 for 10 cycles after frame → tready=0 and io_enable=1 throughout, io_data stable. data_next=1 → frame_cnt increments, tready=1 next cycle.
- Short frame: tlast on beat 5 → len_err pulse, len_err_cnt=1, io_enable stays 0. Next 32-beat frame is delivered correctly.
- Long frame: 40 beats, tlast on beat 39 → len_err once, beats 32..39 dropped, no frame delivered. Following good frame delivered.
- Reset mid-frame: rstn_en low after beat 10 → outputs return to reset values within the cycle. After release, a full 32-beat frame is delivered with frame_cnt=1.
- SEQ_CHECK_EN: frames with low word 1,2,3,5 → seq_err pulses only on the 4th frame, seq_err_cnt=1. A following frame with value 6 passes.
